alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
Sequences commands through the team's 16-bit combinational ALU.
- ALU op codes: 1 add, 2 sub, 3 mul, 4 div, 5 mod. Result is 32 bits. Error[0] = add/sub overflow; Error[1] = div/mod by zero.
- Commands are accepted over a valid/ready interface into a small FIFO.
- The block drives the ALU inputs from registers and holds them stable for a programmable settle time.
- It captures the result and error, returns both over a valid/ready response interface, and keeps an accumulator for chained operations plus a saturating error counter.

Parameters:
DEPTH, 4, command FIFO depth; power of two, at least 2.
SETTLE, 1, cycles the ALU inputs are held before capture; at least 1.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command FIFO can accept
cmd_op  in  4  ALU op code
cmd_a  in  16  operand A
cmd_b  in  16  operand B
cmd_chain  in  1  1 = replace A with acc[15:0] at issue time
alu_a  out  16  registered ALU operand A
alu_b  out  16  registered ALU operand B
alu_op  out  4  registered ALU op; 0 when not driving
alu_result  in  32  ALU result
alu_error  in  2  ALU error code
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer ready
rsp_result  out  32  captured result
rsp_error  out  2  captured error
rsp_op  out  4  op code of this response
busy  out  1  state != IDLE or FIFO non-empty
err_count  out  8  responses with nonzero error; saturates at 255
fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE and the FIFO is emptied.
  - All outputs go to 0, with cmd_ready=1.
  - acc and err_count go to 0.
  - Any in-flight command is dropped with no response.
- Push: a command is pushed when cmd_valid&cmd_ready at a clock edge.
  - cmd_ready = (fifo_count<DEPTH), decoded from registered state.
  - When the FIFO is full, cmd_ready stays 0 even if a pop occurs in the same cycle. There is no bypass path.
- FSM states: IDLE, DRIVE, HOLD.
- IDLE:
  - If the FIFO is non-empty, pop at the edge.
  - Legal op (1..5): load alu_a (cmd_chain ? acc[15:0] : cmd_a), alu_b=cmd_b, alu_op=cmd_op; load the settle counter with SETTLE; go to DRIVE.
  - Illegal op (0, 6..15): do not drive the ALU (alu_op stays 0); load rsp_result=0, rsp_error=2'b11, rsp_op=cmd_op; go to HOLD.
- DRIVE:
  - Decrement the counter each edge.
  - On the edge where the counter equals 1: capture rsp_result=alu_result, rsp_error=alu_error, rsp_op=alu_op; set alu_op=0; go to HOLD.
- HOLD:
  - rsp_valid=1; response fields stay stable until the handshake.
  - On rsp_valid&rsp_ready: if the FIFO is non-empty, pop and issue as in IDLE in the same edge (back-to-back); otherwise go to IDLE.
- Accumulator:
  - acc is written with rsp_result at the capture edge, only when the captured error==2'b00.
  - Error responses and illegal ops leave acc unchanged.
  - cmd_chain resolves acc at issue (pop) time, not at push time. A chained command queued behind its producer therefore sees the producer's result.
- err_count increments at the capture edge (or at the illegal-op load) when the error != 0, and saturates at 255 (no wrap).
- Latency: accept into an empty FIFO in IDLE at edge t0 → pop at t0+1 → rsp_valid high after edge t0+1+SETTLE. Throughput is one response per SETTLE+1 cycles with rsp_ready held high.
- Ordering: responses are returned strictly in command order.
- Simultaneous push and pop: allowed when not full; fifo_count is unchanged. FIFO pointers wrap modulo DEPTH.
- Reset asserted mid-DRIVE or mid-HOLD: immediate clear, no partial response; first push after release is accepted normally.

Test Plan:
1. SETTLE=1; push A=4,B=2,op=1 at edge t0 → rsp_valid high after t0+2; rsp_result=6, rsp_error=0, rsp_op=1, acc=6.
2. Chain: push {op3,A=7,B=2}, then {op1,chain=1,A=999,B=5} back-to-back → responses 14 then 19 in order; alu_a=14 for the second command.
3. Div-by-zero: {op4,A=7,B=0} → rsp_error=2'b10, err_count=1, acc unchanged; then {op1,chain=1,B=1} → acc_prev+1.
4. Backpressure: DEPTH=4, rsp_ready=0, push 6 commands → 5 accepted (1 in HOLD, fifo_count=4), cmd_ready=0; raise rsp_ready → 5 responses in order, one every 2 cycles.
5. Illegal op 9 → alu_op never leaves 0; response result=0, error=2'b11, rsp_op=9; err_count+1. Force err_count to 255 with further errors → stays 255.
6. rst_n pulsed low during DRIVE → rsp_valid=0, fifo_count=0, alu_op=0, acc=0 immediately; that command is never answered. The next command after release completes with normal latency.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues ALU commands, drives the shared ALU,
// and returns captured results with a chaining accumulator.
module alu_op_sequencer #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_op,
    input  logic [15:0]              cmd_a,
    input  logic [15:0]              cmd_b,
    input  logic                     cmd_chain,
    output logic [15:0]              alu_a,
    output logic [15:0]              alu_b,
    output logic [3:0]               alu_op,
    input  logic [31:0]              alu_result,
    input  logic [1:0]               alu_error,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_result,
    output logic [1:0]               rsp_error,
    output logic [3:0]               rsp_op,
    output logic                     busy,
    output logic [7:0]               err_count,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2");
    end
    if (SETTLE < 1) begin : g_bad_settle
        $error("SETTLE must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        HOLD
    } state_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        chain;
    } cmd_t;

    cmd_t            mem [DEPTH];
    cmd_t            head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;

    state_t          state;
    state_t          state_d;
    logic [CW-1:0]   cnt;
    logic [15:0]     acc;

    logic            push;
    logic            pop;
    logic            legal;
    logic            issue_ok;
    logic            issue_bad;
    logic            capture;
    logic            nonempty;

    assign nonempty   = (count != '0);
    assign cmd_ready  = (count < FULL);
    assign push       = cmd_valid & cmd_ready;
    assign head       = mem[rd_ptr];
    assign legal      = (head.op >= 4'd1) && (head.op <= 4'd5);
    assign issue_ok   = pop & legal;
    assign issue_bad  = pop & ~legal;

    assign rsp_valid  = (state == HOLD);
    assign busy       = (state != IDLE) || nonempty;
    assign fifo_count = count;

    // Next state, pop and capture decisions.
    always_comb begin
        state_d = state;
        pop     = 1'b0;
        capture = 1'b0;
        unique case (state)
            IDLE: begin
                if (nonempty) pop = 1'b1;
            end
            DRIVE: begin
                if (cnt == CNT_ONE) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (rsp_ready) begin
                    if (nonempty) pop = 1'b1;
                    else state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) state_d = legal ? DRIVE : HOLD;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_d;
    end

    // Command storage; contents need no reset, occupancy guards reads.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b, cmd_chain};
    end

    // FIFO pointers and occupancy; pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ALU drive registers and settle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            cnt    <= '0;
        end else if (issue_ok) begin
            alu_a  <= head.chain ? acc : head.a;
            alu_b  <= head.b;
            alu_op <= head.op;
            cnt    <= SETTLE_LD;
        end else if (capture) begin
            alu_op <= '0;
            cnt    <= '0;
        end else if (state == DRIVE) begin
            cnt    <= cnt - 1'b1;
        end
    end

    // Response capture; illegal ops answer without touching the ALU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result <= '0;
            rsp_error  <= '0;
            rsp_op     <= '0;
        end else if (capture) begin
            rsp_result <= alu_result;
            rsp_error  <= alu_error;
            rsp_op     <= alu_op;
        end else if (issue_bad) begin
            rsp_result <= '0;
            rsp_error  <= 2'b11;
            rsp_op     <= head.op;
        end
    end

    // Accumulator follows clean results only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc <= '0;
        else if (capture && alu_error == 2'b00) acc <= alu_result[15:0];
    end

    // Saturating count of error responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if ((capture && alu_error != 2'b00) || issue_bad) begin
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

endmodule
